// File: rtl/spm_seq.sv
// spm_seq: sequencer for an external serial-parallel multiplier.
// It accepts an operand pair, presents the multiplicand in parallel and
// serialises the multiplier LSB first. It collects 2*WIDTH product bits
// from the multiplier and then idles the multiplier input for WIDTH cycles
// so its carry-save state drains. The finished product is then held on a
// valid/ready output until the consumer accepts it.
module spm_seq #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic [WIDTH-1:0]     spm_x,
    output logic                 spm_y,
    input  logic                 spm_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int CNT_W = $clog2(3*WIDTH+LAT+1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2*WIDTH+LAT-1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIDTH-1);
    localparam logic [CNT_W-1:0] LAT_C      = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] WIDTH_C    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   out_p_q, out_p_d;
    logic                 spm_y_q, spm_y_d;
    logic                 out_valid_q;
    logic                 in_ready_q;
    logic                 busy_q;

    // Serial multiplier bit for a given count; zero once all WIDTH bits
    // have been sent so the multiplier sees zeros for the high half.
    function automatic logic ser_bit(input logic [WIDTH-1:0] y,
                                     input logic [CNT_W-1:0] idx);
        logic [WIDTH-1:0] sh;
        sh = y >> idx;
        if (idx < WIDTH_C) begin
            return sh[0];
        end else begin
            return 1'b0;
        end
    endfunction

    // Next-state, counter, operand and product-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        prod_d  = prod_q;
        out_p_d = out_p_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    prod_d  = {(2*WIDTH){1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The first LAT samples predate any valid product bit.
                if (cnt_q >= LAT_C) begin
                    prod_d = {spm_p, prod_q[2*WIDTH-1:1]};
                end else begin
                    prod_d = prod_q;
                end
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    out_p_d = prod_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Serial bit for the coming cycle, precomputed so spm_y is a flop output.
    always_comb begin
        spm_y_d = 1'b0;
        if (state_d == ST_SHIFT) begin
            spm_y_d = ser_bit(y_d, cnt_d);
        end else begin
            spm_y_d = 1'b0;
        end
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            x_q         <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            prod_q      <= {(2*WIDTH){1'b0}};
            out_p_q     <= {(2*WIDTH){1'b0}};
            spm_y_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            prod_q      <= prod_d;
            out_p_q     <= out_p_d;
            spm_y_q     <= spm_y_d;
            out_valid_q <= (state_d == ST_DONE);
            in_ready_q  <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    // x_q only changes on accept, so it already holds its value in IDLE/DONE.
    assign spm_x     = x_q;
    assign spm_y     = spm_y_q;
    assign out_p     = out_p_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: randomized and directed checks of spm_seq (WIDTH=8, LAT=1)
// against a behavioural serial-parallel multiplier and x*y arithmetic.
module tb_spm_seq;

    localparam int W       = 8;
    localparam int LAT     = 1;
    localparam int LATENCY = 3*W + LAT + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic [W-1:0]   spm_x;
    logic           spm_y;
    logic           spm_p;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spm_seq #(.WIDTH(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    // Behavioural serial-parallel multiplier: add x when the serial bit is 1,
    // emit the LSB one cycle later, keep the rest as the running partial sum.
    logic [W:0] m_acc;
    logic       m_p;
    logic [W:0] m_sum;
    assign m_sum = m_acc + (spm_y ? {1'b0, spm_x} : {(W+1){1'b0}});
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_acc <= '0;
            m_p   <= 1'b0;
        end else begin
            m_p   <= m_sum[0];
            m_acc <= m_sum >> 1;
        end
    end
    assign spm_p = m_p;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting at a negedge with the block idle.
    // hold=0: out_ready high throughout; hold>0: out_ready low for hold
    // extra DONE cycles, with an in_valid pulse if hold is long enough.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] e, input int hold);
        int n;
        int seq_err;
        int side_err;
        int stab_err;
        bit got;
        logic [W-1:0] sh;
        logic exp_y;
        chk("in_ready_idle", in_ready, 1);
        in_x      = x;
        in_y      = y;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = W'($urandom);
        in_y     = W'($urandom);
        n = 0; seq_err = 0; side_err = 0; got = 1'b0;
        // Cycle n counts from the accept cycle (n=0); cycle n in SHIFT has cnt=n-1.
        while (!got && n < LATENCY + 20) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                got = 1'b1;
            end else begin
                sh    = y >> (n - 1);
                exp_y = (n - 1 < W) ? sh[0] : 1'b0;
                if (spm_y !== exp_y) seq_err++;
                if (spm_x !== x) seq_err++;
                if (busy !== 1'b1 || in_ready !== 1'b0) side_err++;
            end
        end
        chk("done_reached", got, 1);
        chk("latency", n, LATENCY);
        chk("spm_stream", seq_err, 0);
        chk("busy_flags", side_err, 0);
        chk("out_p", out_p, e);
        if (hold > 0) begin
            stab_err = 0;
            for (int i = 0; i < hold; i++) begin
                in_valid = (i == 3);
                in_x     = W'($urandom);
                in_y     = W'($urandom);
                @(negedge clk);
                if (out_valid !== 1'b1 || out_p !== e || in_ready !== 1'b0 || busy !== 1'b1)
                    stab_err++;
            end
            in_valid = 1'b0;
            chk("done_stable", stab_err, 0);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("valid_drop", out_valid, 0);
        chk("ready_back", in_ready, 1);
        chk("out_p_hold", out_p, e);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [2*W-1:0] re;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_x      = 8'hAA;
        in_y      = 8'h55;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_spm_y", spm_y, 0);
        chk("rst_spm_x", spm_x, 0);
        in_valid = 1'b0;
        rst      = 1'b1;

        do_op(8'hFF, 8'hFF, 16'hFE01, 0);
        do_op(8'h00, 8'hA5, 16'h0000, 0);
        do_op(8'h01, 8'h80, 16'h0080, 2);
        do_op(8'h5A, 8'h3B, 16'h14BE, 10);
        do_op(8'h12, 8'h34, 16'h03A8, 0);
        do_op(8'hC3, 8'h3C, 16'h2DB4, 0);

        // Abort mid-SHIFT at cnt=5.
        in_x     = 8'hE7;
        in_y     = 8'h9D;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_pre_abort", busy, 1);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_p", out_p, 0);
        chk("abort_spm_y", spm_y, 0);
        chk("abort_spm_x", spm_x, 0);
        @(negedge clk);
        rst = 1'b1;
        do_op(8'h03, 8'h05, 16'h000F, 0);

        for (int k = 0; k < 12; k++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            re = (2*W)'(rx) * (2*W)'(ry);
            do_op(rx, ry, re, int'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_seq.md
SPM_SEQ -- requirements
Module: spm_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (supported range 4..64).
REQ-002 SHALL have parameter LAT, default 1, giving the cycles from spm_y driven to the matching spm_p bit (supported range 0..3).
REQ-003 SHALL have port clk, input, 1 bit: single clock; every flop is rising-edge triggered.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand pair.
REQ-007 SHALL have port in_x, input, WIDTH bits: parallel multiplicand.
REQ-008 SHALL have port in_y, input, WIDTH bits: multiplier, serialised by this block.
REQ-009 SHALL have port spm_x, output, WIDTH bits: parallel operand to the serial-parallel multiplier.
REQ-010 SHALL have port spm_y, output, 1 bit: serial multiplier bit to the multiplier.
REQ-011 SHALL have port spm_p, input, 1 bit: serial product bit from the multiplier.
REQ-012 SHALL have port out_valid, output, 1 bit: product available.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-014 SHALL have port out_p, output, 2*WIDTH bits: unsigned product in_x*in_y.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL implement a state machine with states IDLE, SHIFT, DRAIN and DONE; one counter cnt SHALL cover all phases.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready, SHALL register x_q<=in_x and y_q<=in_y, clear the product register and cnt, and go to SHIFT next cycle.
REQ-018 spm_x SHALL equal x_q in SHIFT and DRAIN; it SHALL hold its last value in IDLE and DONE.
REQ-019 SHIFT lasts exactly 2*WIDTH+LAT cycles, with cnt=0..2*WIDTH+LAT-1.
REQ-020 In SHIFT, spm_y SHALL be y_q[cnt] for cnt<WIDTH and 0 otherwise (LSB first).
REQ-021 In SHIFT, for cnt>=LAT, spm_p SHALL be sampled and shifted into the MSB of the 2*WIDTH product register (right shift), giving exactly 2*WIDTH captures; bit k of the product comes from the sample at cnt=k+LAT.
REQ-022 DRAIN: spm_y=0 for exactly WIDTH cycles to flush the multiplier's carry-save state; spm_p SHALL be ignored; then go to DONE.
REQ-023 DONE: out_valid=1 and out_p=product register, both stable until out_valid&out_ready; on that handshake go to IDLE next cycle.
REQ-024 out_p SHALL hold its value after the handshake until the next operand pair is accepted.
REQ-025 in_ready SHALL be 0 in SHIFT, DRAIN and DONE; in_valid in those states SHALL be ignored with no state change.
REQ-026 spm_y SHALL be 0 outside SHIFT.
REQ-027 Total latency from the accept edge to out_valid SHALL be 3*WIDTH+LAT+1 cycles.
REQ-028 If out_ready is already high when DONE is entered, the handshake SHALL complete in that first DONE cycle.
REQ-029 Back-to-back: in_ready SHALL rise in the cycle after the output handshake (no combinational path from out_ready to in_ready).
REQ-030 All arithmetic SHALL be unsigned; cnt width SHALL be clog2(3*WIDTH+LAT+1).

Reset
REQ-031 While rst=0, asynchronously: state=IDLE; cnt, x_q, y_q, product register and out_p =0; spm_y=0; out_valid=0; busy=0; in_ready=1.
REQ-032 Reset asserted mid-SHIFT or mid-DRAIN SHALL abort the operation with no output produced; the multiplier, which shares rst, SHALL be cleared by that same reset.
REQ-033 After rst deasserts, the first operand SHALL be accepted on the first rising edge with in_valid=1.

Verification (WIDTH=8, LAT=1, behavioural spm model)
REQ-034 in_x=8'hFF, in_y=8'hFF, out_ready=1 -> out_p=16'hFE01, out_valid high exactly 26 cycles after accept, for one cycle.
REQ-035 in_x=8'h00, in_y=8'hA5 -> out_p=16'h0000; in_x=8'h01, in_y=8'h80 -> out_p=16'h0080.
REQ-036 out_ready held low 10 cycles in DONE -> out_valid and out_p stable throughout; in_ready=0; an in_valid pulse is ignored.
REQ-037 rst pulsed low at cnt=5 of SHIFT -> all outputs reach reset values immediately; a following 8'h03*8'h05 -> out_p=16'h000F.
REQ-038 Two back-to-back ops (8'h12*8'h34, then 8'hC3*8'h3C) -> 16'h03A8 then 16'h2DB4, with no residual carry corrupting the second result.
